// File: rtl/voting_pkg.sv
// Shared types and helpers for the voting machine: press-FSM state encoding
// and one-hot decode utilities sized for up to 16 candidates.
package voting_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, LOGGED, WAIT_REL} state_t;

  localparam int MAX_CAND = 16;

  function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_CAND; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_CAND-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CAND; i++) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/vote_press_detect.sv
// Button-press qualifier: debounces a held press, checks the candidate select
// and produces accept/reject pulses plus the "vote logged" level.
module vote_press_detect
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                button,
  input  logic [NUM_CAND-1:0] candidate,
  output logic                count_en,
  output logic                accept,
  output logic                reject,
  output logic [NUM_CAND-1:0] cand_q,
  output logic                logged
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;

  // count_en strobes in the same cycle the FSM decides to accept, so the
  // tally and the registered vote_ok pulse update on the same edge.
  assign hold_done = (state == HOLD) && !mode && button && (candidate == cand_q) &&
                     (hold_cnt == HW'(HOLD_CYCLES));
  assign count_en  = hold_done && is_onehot(MAX_CAND'(cand_q));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      cand_q   <= '0;
      accept   <= 1'b0;
      reject   <= 1'b0;
      logged   <= 1'b0;
    end else begin
      accept <= 1'b0;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (!mode && button) begin
            cand_q   <= candidate;
            hold_cnt <= HW'(1);
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (mode || !button) begin
            state <= IDLE;
          end else if (candidate != cand_q) begin
            reject <= 1'b1;
            state  <= WAIT_REL;
          end else if (hold_done) begin
            accept <= count_en;
            reject <= !count_en;
            logged <= count_en;
            state  <= count_en ? LOGGED : WAIT_REL;
          end else begin
            hold_cnt <= HW'(hold_cnt + 1'b1);
          end
        end
        LOGGED: begin
          if (!button) begin
            logged <= 1'b0;
            state  <= IDLE;
          end
        end
        WAIT_REL: begin
          if (!button) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/voting_machine_param.sv
// Multi-candidate voting machine top: per-candidate saturating tallies and
// result mux. Define TOTAL_COUNT_EN to add the total_votes output.
module voting_machine_param
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                button,
  input  logic [NUM_CAND-1:0] candidate,
  output logic                vote_ok,
  output logic                vote_led,
  output logic                vote_err,
  output logic [CNT_W-1:0]    count_out,
  output logic                sat
`ifdef TOTAL_COUNT_EN
  ,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0] total_votes
`endif
);

  logic                count_en;
  logic [NUM_CAND-1:0] cand_q;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic [3:0]          sel_idx;
  logic [CNT_W-1:0]    sel_tally;

  vote_press_detect #(
    .NUM_CAND    (NUM_CAND),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_press (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .button    (button),
    .candidate (candidate),
    .count_en  (count_en),
    .accept    (vote_ok),
    .reject    (vote_err),
    .cand_q    (cand_q),
    .logged    (vote_led)
  );

  // NOTE: the tally array is architectural state that reset must clear, so it
  // is a reset register file rather than an un-reset RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++)
        if (count_en && cand_q[i] && (tally[i] != '1)) tally[i] <= tally[i] + 1'b1;
    end
  end

  assign sel_idx = onehot_to_idx(MAX_CAND'(candidate));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_tally = '0;
    sat       = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (4'(i) == sel_idx) sel_tally = tally[i];
      if (tally[i] == '1)   sat       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                       count_out <= '0;
    else if (mode && is_onehot(MAX_CAND'(candidate))) count_out <= sel_tally;
    else                                             count_out <= '0;
  end

`ifdef TOTAL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                             total_votes <= '0;
    else if (count_en && total_votes != '1) total_votes <= total_votes + 1'b1;
  end
`endif

endmodule

// File: tb/tb_voting_machine_param.sv
// Self-checking bench: directed scenarios plus random presses, compared every
// cycle against a press-level reference model of the voting rules.
module tb_voting_machine_param;

  localparam int NC   = 4;
  localparam int CW   = 3;
  localparam int HC   = 16;
  localparam int TW   = CW + $clog2(NC);
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset, mode, button;
  logic [NC-1:0] candidate;
  logic          vote_ok, vote_led, vote_err, sat;
  logic [CW-1:0] count_out;
`ifdef TOTAL_COUNT_EN
  logic [TW-1:0] total_votes;
`endif

  always #5 clk = ~clk;

  voting_machine_param #(
    .NUM_CAND    (NC),
    .CNT_W       (CW),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .button    (button),
    .candidate (candidate),
    .vote_ok   (vote_ok),
    .vote_led  (vote_led),
    .vote_err  (vote_err),
    .count_out (count_out),
    .sat       (sat)
`ifdef TOTAL_COUNT_EN
    ,
    .total_votes (total_votes)
`endif
  );

  int checks = 0;
  int errors = 0;
  int ok_seen = 0;
  int err_seen = 0;

  // Reference model: tallies as plain integers, and the current press tracked
  // as "samples held so far" plus a lock that waits for release.
  int            m_tally [NC];
  int            m_total;
  int            press_len;
  logic [NC-1:0] press_cand;
  bit            locked, led, e_ok, e_err;
  int            e_cnt;

  function automatic bit onehot(input logic [NC-1:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int idx_of(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    e_ok  = 1'b0;
    e_err = 1'b0;
    if (reset) begin
      for (int i = 0; i < NC; i++) m_tally[i] = 0;
      m_total = 0; press_len = 0; locked = 0; led = 0; e_cnt = 0;
    end else begin
      e_cnt = (mode && onehot(candidate)) ? m_tally[idx_of(candidate)] : 0;
      if (locked) begin
        if (!button) begin locked = 0; led = 0; end
      end else if (press_len > 0) begin
        if (mode || !button) press_len = 0;
        else if (candidate != press_cand) begin
          e_err = 1; locked = 1; press_len = 0;
        end else if (press_len == HC) begin
          press_len = 0; locked = 1;
          if (onehot(press_cand)) begin
            e_ok = 1; led = 1;
            if (m_tally[idx_of(press_cand)] < CMAX) m_tally[idx_of(press_cand)]++;
            if (m_total < TMAX) m_total++;
          end else e_err = 1;
        end else press_len++;
      end else if (!mode && button) begin
        press_len = 1; press_cand = candidate;
      end
    end
  endtask

  task automatic step();
    bit e_sat;
    @(posedge clk);
    model_edge();
    #1;
    e_sat = 0;
    for (int i = 0; i < NC; i++) if (m_tally[i] == CMAX) e_sat = 1;
    check("vote_ok", vote_ok, e_ok);
    check("vote_err", vote_err, e_err);
    check("vote_led", vote_led, led);
    check("count_out", count_out, e_cnt);
    check("sat", sat, e_sat);
`ifdef TOTAL_COUNT_EN
    check("total_votes", total_votes, m_total);
`endif
    if (vote_ok === 1'b1) ok_seen++;
    if (vote_err === 1'b1) err_seen++;
  endtask

  task automatic press(input logic [NC-1:0] c, input int n);
    mode = 0; candidate = c; button = 1;
    repeat (n) step();
    button = 0;
    step();
  endtask

  task automatic read(input logic [NC-1:0] c, input int exp);
    mode = 1; candidate = c; button = 0;
    step();
    check("read_count", count_out, exp);
    mode = 0;
  endtask

  initial begin
    int ok0, err0;
    logic [NC-1:0] ctab [8];
    ctab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0110, 4'b1001, 4'b1111};

    // 1: reset, one valid vote for candidate 1, then read it back
    reset = 1; mode = 0; button = 0; candidate = '0;
    step(); step();
    check("rst_count_out", count_out, 0);
    check("rst_led", vote_led, 0);
    reset = 0;
    step();
    ok0 = ok_seen;
    press(4'b0010, HC + 6);
    check("t1_ok_pulses", ok_seen - ok0, 1);
    read(4'b0010, 1);

    // 2: multi-hot select rejected once, long hold gives nothing more
    ok0 = ok_seen; err0 = err_seen;
    press(4'b0110, HC + 1 + 40);
    check("t2_err_pulses", err_seen - err0, 1);
    check("t2_ok_pulses", ok_seen - ok0, 0);

    // 3: bounce rejection
    ok0 = ok_seen; err0 = err_seen;
    candidate = 4'b0001;
    repeat (10) begin
      button = 1; repeat (5) step();
      button = 0; repeat (3) step();
    end
    check("t3_pulses", (ok_seen - ok0) + (err_seen - err0), 0);
    read(4'b0001, 0);

    // 4: saturation of candidate 0 at 7
    ok0 = ok_seen;
    for (int v = 1; v <= 9; v++) begin
      press(4'b0001, HC + 1);
      if (v == 7) check("t4_sat_at_7", sat, 1);
    end
    check("t4_ok_pulses", ok_seen - ok0, 9);
    read(4'b0001, 7);

    // 5: mode raised mid-hold aborts silently
    ok0 = ok_seen; err0 = err_seen;
    mode = 0; candidate = 4'b1000; button = 1;
    repeat (8) step();
    mode = 1;
    repeat (10) step();
    button = 0; mode = 0;
    step();
    check("t5_pulses", (ok_seen - ok0) + (err_seen - err0), 0);
    read(4'b1000, 0);

    // 5b: reset while LOGGED
    mode = 0; candidate = 4'b0100; button = 1;
    repeat (HC + 4) step();
    check("t5_led_logged", vote_led, 1);
    reset = 1;
    step();
    check("t5_led_after_rst", vote_led, 0);
    check("t5_sat_after_rst", sat, 0);
    reset = 0; button = 0;
    step();
    read(4'b0001, 0);

    // 6: 3 votes c0, 2 votes c2, 1 rejected press
    repeat (3) press(4'b0001, HC + 1);
    repeat (2) press(4'b0100, HC + 1);
    press(4'b0101, HC + 1);
    read(4'b0001, 3);
    read(4'b0100, 2);
`ifdef TOTAL_COUNT_EN
    check("t6_total", total_votes, 5);
`endif

    // Random presses against the model
    for (int it = 0; it < 60; it++) begin
      int len;
      bit chg, abort;
      len   = $urandom_range(1, HC + 6);
      chg   = ($urandom_range(0, 4) == 0);
      abort = ($urandom_range(0, 5) == 0);
      mode = 0; candidate = ctab[$urandom_range(0, 7)]; button = 1;
      for (int k = 0; k < len; k++) begin
        if (chg && k == len / 2) candidate = candidate ^ 4'b0011;
        if (abort && k == len / 3) mode = 1;
        step();
      end
      button = 0; mode = 0;
      repeat ($urandom_range(1, 3)) step();
      if ($urandom_range(0, 2) == 0) begin
        mode = 1; candidate = ctab[$urandom_range(0, 7)];
        repeat (2) step();
        mode = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
